// File: rtl/i2c_pkg.sv
// Shared I2C datapath definitions: FSM state encoding and ACK-slot levels.
package i2c_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_ACK  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_down_counter.sv
// Loadable saturating down counter with a registered zero flag.
module i2c_down_counter #(
   parameter int unsigned   W       = 4,
   parameter logic [W-1:0]  RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         is_zero
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         is_zero_q, is_zero_d;

   // Load has priority; a decrement at zero holds rather than wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
      is_zero_d = (cnt_d == '0);
   end

   // Counter and zero-flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= RST_VAL;
         is_zero_q <= (RST_VAL == '0);
      end else begin
         cnt_q     <= cnt_d;
         is_zero_q <= is_zero_d;
      end
   end

   assign cnt     = cnt_q;
   assign is_zero = is_zero_q;

endmodule

// File: rtl/i2c_xfer_counter.sv
// I2C master bit/byte sequencer: data bit index, ACK slot, bytes remaining.
module i2c_xfer_counter
   import i2c_pkg::*;
#(
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned LEN_W        = 4,
   parameter int unsigned STOP_ON_NACK = 1,
   localparam int unsigned IDX_W       = $clog2(DATA_BITS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [LEN_W-1:0] len,
   input  logic             bit_tick,
   input  logic             ack_in,
   input  logic             abort,
   output logic             busy,
   output logic [IDX_W-1:0] bit_idx,
   output logic             ack_phase,
   output logic [LEN_W-1:0] bytes_left,
   output logic             byte_done,
   output logic             xfer_done,
   output logic             nack
);

   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_BITS - 1);

   state_e state_q, state_d;
   logic   busy_q, busy_d;
   logic   ack_phase_q, ack_phase_d;
   logic   byte_done_q, byte_done_d;
   logic   xfer_done_q, xfer_done_d;
   logic   nack_q, nack_d;

   logic   bit_load, bit_dec, bit_zero;
   logic   byte_load, byte_dec, bytes_zero;
   logic   last_byte, nack_seen;

   i2c_down_counter #(
      .W       (IDX_W),
      .RST_VAL (IDX_MAX)
   ) u_bit_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (bit_load),
      .load_val (IDX_MAX),
      .dec      (bit_dec),
      .cnt      (bit_idx),
      .is_zero  (bit_zero)
   );

   i2c_down_counter #(
      .W       (LEN_W),
      .RST_VAL ('0)
   ) u_byte_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (byte_load),
      .load_val (len),
      .dec      (byte_dec),
      .cnt      (bytes_left),
      .is_zero  (bytes_zero)
   );

   // An empty byte count in ACK cannot occur normally; treat it as last to stay safe.
   assign last_byte = (bytes_left == LEN_W'(1)) || bytes_zero;
   assign nack_seen = (ack_in == I2C_NACK);

   // Next-state, counter controls and registered-output next values.
   always_comb begin
      state_d     = state_q;
      bit_load    = 1'b0;
      bit_dec     = 1'b0;
      byte_load   = 1'b0;
      byte_dec    = 1'b0;
      byte_done_d = 1'b0;
      nack_d      = nack_q;

      unique case (state_q)
         ST_IDLE: begin
            if (load) begin
               nack_d = 1'b0;
               if (len != '0) begin
                  state_d   = ST_DATA;
                  bit_load  = 1'b1;
                  byte_load = 1'b1;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DATA: begin
            if (abort) begin
               state_d  = ST_IDLE;
               bit_load = 1'b1;
            end else if (bit_tick) begin
               if (bit_zero) begin
                  state_d = ST_ACK;
               end else begin
                  bit_dec = 1'b1;
               end
            end
         end
         ST_ACK: begin
            if (abort) begin
               state_d  = ST_IDLE;
               bit_load = 1'b1;
            end else if (bit_tick) begin
               byte_done_d = 1'b1;
               byte_dec    = 1'b1;
               if (nack_seen) begin
                  nack_d = 1'b1;
               end
               if ((nack_seen && (STOP_ON_NACK != 0)) || last_byte) begin
                  state_d = ST_DONE;
               end else begin
                  state_d  = ST_DATA;
                  bit_load = 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            if (abort) begin
               bit_load = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d      = (state_d == ST_DATA) || (state_d == ST_ACK);
      ack_phase_d = (state_d == ST_ACK);
      xfer_done_d = (state_d == ST_DONE);
   end

   // State and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         busy_q      <= 1'b0;
         ack_phase_q <= 1'b0;
         byte_done_q <= 1'b0;
         xfer_done_q <= 1'b0;
         nack_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         ack_phase_q <= ack_phase_d;
         byte_done_q <= byte_done_d;
         xfer_done_q <= xfer_done_d;
         nack_q      <= nack_d;
      end
   end

   assign busy      = busy_q;
   assign ack_phase = ack_phase_q;
   assign byte_done = byte_done_q;
   assign xfer_done = xfer_done_q;
   assign nack      = nack_q;

endmodule

// File: tb/tb_i2c_xfer_counter.sv
// Directed vector bench for i2c_xfer_counter; two instances differ only in STOP_ON_NACK.
module tb_i2c_xfer_counter;

   typedef struct packed {
      logic       load;
      logic [3:0] len;
      logic       tick;
      logic       ack;
      logic       abort;
   } in_t;

   typedef struct packed {
      logic       busy;
      logic [2:0] idx;
      logic       ackp;
      logic [3:0] bl;
      logic       bd;
      logic       xd;
      logic       nk;
   } out_t;

   typedef struct {
      int   seq;
      in_t  i;
      out_t es;   // expected, STOP_ON_NACK=1
      out_t ec;   // expected, STOP_ON_NACK=0
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       load, bit_tick, ack_in, abort;
   logic [3:0] len;

   logic       s_busy, s_ackp, s_bd, s_xd, s_nk;
   logic [2:0] s_idx;
   logic [3:0] s_bl;
   logic       c_busy, c_ackp, c_bd, c_xd, c_nk;
   logic [2:0] c_idx;
   logic [3:0] c_bl;

   int n_vec  = 0;
   int n_fail = 0;
   vec_t vq[$];

   always #5 clk = ~clk;

   i2c_xfer_counter #(.DATA_BITS(8), .LEN_W(4), .STOP_ON_NACK(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .load(load), .len(len), .bit_tick(bit_tick),
      .ack_in(ack_in), .abort(abort), .busy(s_busy), .bit_idx(s_idx),
      .ack_phase(s_ackp), .bytes_left(s_bl), .byte_done(s_bd),
      .xfer_done(s_xd), .nack(s_nk));

   i2c_xfer_counter #(.DATA_BITS(8), .LEN_W(4), .STOP_ON_NACK(0)) dut_c (
      .clk(clk), .rst_n(rst_n), .load(load), .len(len), .bit_tick(bit_tick),
      .ack_in(ack_in), .abort(abort), .busy(c_busy), .bit_idx(c_idx),
      .ack_phase(c_ackp), .bytes_left(c_bl), .byte_done(c_bd),
      .xfer_done(c_xd), .nack(c_nk));

   function automatic out_t mk(logic b, logic [2:0] ix, logic ap, logic [3:0] bl,
                               logic bd, logic xd, logic nk);
      out_t o;
      o.busy = b; o.idx = ix; o.ackp = ap; o.bl = bl; o.bd = bd; o.xd = xd; o.nk = nk;
      return o;
   endfunction

   function automatic in_t mi(logic ld, logic [3:0] ln, logic tk, logic ak, logic ab);
      in_t i;
      i.load = ld; i.len = ln; i.tick = tk; i.ack = ak; i.abort = ab;
      return i;
   endfunction

   function automatic void push2(int seq, in_t i, out_t es, out_t ec);
      vec_t v;
      v.seq = seq; v.i = i; v.es = es; v.ec = ec;
      vq.push_back(v);
   endfunction

   function automatic void push(int seq, in_t i, out_t e);
      push2(seq, i, e, e);
   endfunction

   function automatic out_t got_s();
      return mk(s_busy, s_idx, s_ackp, s_bl, s_bd, s_xd, s_nk);
   endfunction

   function automatic out_t got_c();
      return mk(c_busy, c_idx, c_ackp, c_bl, c_bd, c_xd, c_nk);
   endfunction

   // Drive inputs on the falling edge, then look at outputs 1 time unit after the rising edge.
   task automatic step(input in_t i);
      @(negedge clk);
      load = i.load; len = i.len; bit_tick = i.tick; ack_in = i.ack; abort = i.abort;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input int seq, input int k, input out_t es, input out_t ec);
      out_t gs, gc;
      gs = got_s();
      gc = got_c();
      n_vec++;
      if (gs !== es || gc !== ec) begin
         n_fail++;
         $display("FAIL seq%0d vec%0d: stop1 got %h want %h | stop0 got %h want %h",
                  seq, k, gs, es, gc, ec);
      end
   endtask

   // Eight DATA ticks of one byte: index 7 down to 0, then into the ACK slot.
   function automatic void data_byte(int seq, logic [3:0] bl, logic nk);
      for (int k = 1; k <= 7; k++)
         push(seq, mi(0, 0, 1, 0, 0), mk(1, 3'(7 - k), 0, bl, 0, 0, nk));
      push(seq, mi(0, 0, 1, 0, 0), mk(1, 3'd0, 1, bl, 0, 0, nk));
   endfunction

   initial begin
      out_t idle_s;

      // seq1: len=2, all ACK
      push(1, mi(1, 4'd2, 0, 0, 0), mk(1, 3'd7, 0, 4'd2, 0, 0, 0));
      data_byte(1, 4'd2, 0);
      push(1, mi(0, 0, 1, 0, 0), mk(1, 3'd7, 0, 4'd1, 1, 0, 0));
      data_byte(1, 4'd1, 0);
      push(1, mi(0, 0, 1, 0, 0), mk(0, 3'd0, 0, 4'd0, 1, 1, 0));
      push(1, mi(0, 0, 0, 0, 0), mk(0, 3'd0, 0, 4'd0, 0, 0, 0));

      // seq2: len=3, NACK on first ACK; stop vs continue
      push(2, mi(1, 4'd3, 0, 0, 0), mk(1, 3'd7, 0, 4'd3, 0, 0, 0));
      data_byte(2, 4'd3, 0);
      push2(2, mi(0, 0, 1, 1, 0), mk(0, 3'd0, 0, 4'd2, 1, 1, 1), mk(1, 3'd7, 0, 4'd2, 1, 0, 1));
      idle_s = mk(0, 3'd0, 0, 4'd2, 0, 0, 1);
      for (int k = 1; k <= 7; k++)
         push2(2, mi(0, 0, 1, 0, 0), idle_s, mk(1, 3'(7 - k), 0, 4'd2, 0, 0, 1));
      push2(2, mi(0, 0, 1, 0, 0), idle_s, mk(1, 3'd0, 1, 4'd2, 0, 0, 1));
      push2(2, mi(0, 0, 1, 0, 0), idle_s, mk(1, 3'd7, 0, 4'd1, 1, 0, 1));
      for (int k = 1; k <= 7; k++)
         push2(2, mi(0, 0, 1, 0, 0), idle_s, mk(1, 3'(7 - k), 0, 4'd1, 0, 0, 1));
      push2(2, mi(0, 0, 1, 0, 0), idle_s, mk(1, 3'd0, 1, 4'd1, 0, 0, 1));
      push2(2, mi(0, 0, 1, 0, 0), idle_s, mk(0, 3'd0, 0, 4'd0, 1, 1, 1));
      push2(2, mi(0, 0, 0, 0, 0), idle_s, mk(0, 3'd0, 0, 4'd0, 0, 0, 1));

      // seq3: abort together with tick at bit_idx=3, then a clean len=1 transfer
      push(3, mi(1, 4'd1, 0, 0, 0), mk(1, 3'd7, 0, 4'd1, 0, 0, 0));
      for (int k = 1; k <= 4; k++)
         push(3, mi(0, 0, 1, 0, 0), mk(1, 3'(7 - k), 0, 4'd1, 0, 0, 0));
      push(3, mi(0, 0, 1, 0, 1), mk(0, 3'd7, 0, 4'd1, 0, 0, 0));
      push(3, mi(0, 0, 1, 1, 1), mk(0, 3'd7, 0, 4'd1, 0, 0, 0));
      push(3, mi(1, 4'd1, 0, 0, 0), mk(1, 3'd7, 0, 4'd1, 0, 0, 0));
      data_byte(3, 4'd1, 0);
      push(3, mi(0, 0, 1, 0, 0), mk(0, 3'd0, 0, 4'd0, 1, 1, 0));
      push(3, mi(0, 0, 0, 0, 0), mk(0, 3'd0, 0, 4'd0, 0, 0, 0));

      // seq4: len=0, load ignored while busy and in DONE, load beats abort in IDLE
      push(4, mi(1, 4'd0, 1, 0, 0), mk(0, 3'd0, 0, 4'd0, 0, 1, 0));
      push(4, mi(0, 0, 0, 0, 0), mk(0, 3'd0, 0, 4'd0, 0, 0, 0));
      push(4, mi(1, 4'd2, 0, 0, 0), mk(1, 3'd7, 0, 4'd2, 0, 0, 0));
      for (int k = 1; k <= 3; k++)
         push(4, mi(1, 4'd5, 1, 0, 0), mk(1, 3'(7 - k), 0, 4'd2, 0, 0, 0));
      push(4, mi(0, 0, 0, 0, 1), mk(0, 3'd7, 0, 4'd2, 0, 0, 0));
      push(4, mi(1, 4'd1, 0, 0, 1), mk(1, 3'd7, 0, 4'd1, 0, 0, 0));
      push(4, mi(0, 0, 0, 0, 1), mk(0, 3'd7, 0, 4'd1, 0, 0, 0));
      push(4, mi(1, 4'd0, 0, 0, 0), mk(0, 3'd7, 0, 4'd1, 0, 1, 0));
      push(4, mi(1, 4'd2, 0, 0, 0), mk(0, 3'd7, 0, 4'd1, 0, 0, 0));

      // seq5: run into the ACK slot; reset is applied by hand below
      push(5, mi(1, 4'd1, 0, 0, 0), mk(1, 3'd7, 0, 4'd1, 0, 0, 0));
      data_byte(5, 4'd1, 0);

      // Reset and apply
      rst_n = 1'b0; load = 0; len = 0; bit_tick = 0; ack_in = 0; abort = 0;
      repeat (3) @(posedge clk);
      #1;
      check(0, 0, mk(0, 3'd7, 0, 4'd0, 0, 0, 0), mk(0, 3'd7, 0, 4'd0, 0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < vq.size(); k++) begin
         step(vq[k].i);
         check(vq[k].seq, k, vq[k].es, vq[k].ec);
      end

      // Asynchronous reset mid-ACK: outputs clear before any clock edge.
      load = 0; bit_tick = 0; ack_in = 0; abort = 0;
      #2;
      rst_n = 1'b0;
      #1;
      check(6, 0, mk(0, 3'd7, 0, 4'd0, 0, 0, 0), mk(0, 3'd7, 0, 4'd0, 0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step(mi(0, 0, 1, 0, 0));
         check(6, k, mk(0, 3'd7, 0, 4'd0, 0, 0, 0), mk(0, 3'd7, 0, 4'd0, 0, 0, 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
